// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared screen geometry, ADC width and paddle tracker FSM states
package breakout_pkg;

   localparam int ADC_W        = 12;
   localparam int SCREEN_W     = 320;
   localparam int PADDLE_W     = 32;
   localparam int PADDLE_RANGE = SCREEN_W - PADDLE_W;
   localparam int POS_W        = 9;
   // avg (ADC_W bits) times PADDLE_RANGE (< 2^9) fits in 21 bits
   localparam int PROD_W       = ADC_W + POS_W;

   typedef enum logic [1:0] {
      SETTLE,
      ACCUM,
      SCALE,
      UPDATE
   } tracker_state_t;

endpackage

// File: rtl/sample_timer.sv
// rtl/sample_timer.sv - free-running 0..PERIOD-1 counter, tick on the terminal count
module sample_timer #(
   parameter int PERIOD = 50000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(PERIOD - 1));

   always_ff @(posedge clk) begin
      if (reset || tick)
         count <= '0;
      else
         count <= count + CW'(1);
   end

endmodule

// File: rtl/paddle_tracker.sv
// rtl/paddle_tracker.sv - averages paddle pot samples and scales them to a paddle x-coordinate
// Optional deadband on position updates is enabled by defining PADDLE_HYST_EN.
module paddle_tracker
   import breakout_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 50000,
   parameter int AVG_LOG2      = 3,
   parameter int ADC_CHAN      = 0,
   parameter int HYST          = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ADC_W-1:0] adc_result,
   input  logic             hold,
   output logic [2:0]       chan,
   output logic [POS_W-1:0] pos,
   output logic             pos_valid
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int NSAMP = 1 << AVG_LOG2;

   tracker_state_t state, next_state;

   logic              tick;
   logic              acc_en, acc_clr, do_scale, do_update, move;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic [ADC_W-1:0]  avg;
   logic [PROD_W-1:0] prod;
   logic [POS_W-1:0]  new_pos;

   sample_timer #(
      .PERIOD (SAMPLE_PERIOD)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign chan    = 3'(ADC_CHAN);
   assign avg     = ADC_W'(acc >> AVG_LOG2);
   assign new_pos = POS_W'(prod >> ADC_W);

   always_ff @(posedge clk) begin
      if (reset)
         state <= SETTLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      acc_en     = 1'b0;
      acc_clr    = 1'b0;
      do_scale   = 1'b0;
      do_update  = 1'b0;
      case (state)
         // the first tick after reset may carry a stale conversion
         SETTLE: begin
            if (tick) begin
               acc_clr    = 1'b1;
               next_state = ACCUM;
            end
         end
         ACCUM: begin
            if (tick && !hold) begin
               acc_en = 1'b1;
               if (cnt == CNT_W'(NSAMP - 1))
                  next_state = SCALE;
            end
         end
         SCALE: begin
            do_scale   = 1'b1;
            next_state = UPDATE;
         end
         UPDATE: begin
            do_update  = 1'b1;
            acc_clr    = 1'b1;
            next_state = ACCUM;
         end
         default: next_state = SETTLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         prod      <= '0;
         pos       <= POS_W'(PADDLE_RANGE / 2);
         pos_valid <= 1'b0;
      end else begin
         pos_valid <= do_update;
         if (acc_clr) begin
            acc <= '0;
            cnt <= '0;
         end else if (acc_en) begin
            acc <= acc + ACC_W'(adc_result);
            cnt <= cnt + CNT_W'(1);
         end
         if (do_scale)
            prod <= PROD_W'(avg) * PROD_W'(PADDLE_RANGE);
         if (do_update && move)
            pos <= new_pos;
      end
   end

`ifdef PADDLE_HYST_EN
   logic             first;
   logic [POS_W-1:0] delta;

   assign delta = (new_pos > pos) ? (new_pos - pos) : (pos - new_pos);
   assign move  = first || (delta >= POS_W'(HYST));

   // first batch after reset always lands, whatever the deadband
   always_ff @(posedge clk) begin
      if (reset)
         first <= 1'b1;
      else if (do_update)
         first <= 1'b0;
   end
`else
   assign move = 1'b1;
`endif

endmodule

// File: tb/tb_paddle_tracker.sv
// tb/tb_paddle_tracker.sv - randomized and directed bench for paddle_tracker against a batch-level model
module tb_paddle_tracker;

   logic        clk;
   logic        reset;
   logic [11:0] adc_result;
   logic        hold;
   logic [2:0]  chan;
   logic [8:0]  pos;
   logic        pos_valid;

   int tests = 0;
   int fails = 0;
   int t = 0;

   int         got_t[$];
   logic [8:0] got_pos[$];
   int         ep_t[$];
   logic [8:0] ep_pos[$];
   int         sv[$];
   bit         sh[$];

   paddle_tracker #(
      .SAMPLE_PERIOD (4),
      .AVG_LOG2      (3),
      .ADC_CHAN      (0),
      .HYST          (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .adc_result (adc_result),
      .hold       (hold),
      .chan       (chan),
      .pos        (pos),
      .pos_valid  (pos_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // t is the cycle index since reset release (cycle 0 = first cycle with reset low)
   always @(posedge clk) begin
      if (reset) t <= 0;
      else       t <= t + 1;
   end

   always @(negedge clk) begin
      if (!reset && pos_valid) begin
         got_t.push_back(t);
         got_pos.push_back(pos);
      end
   end

   // Window w spans cycles 4w..4w+3 and its tick samples sv[w]. Window 0 is the settle tick.
   // A batch completed by the tick of window w reports in cycle 4w+3+3.
   task automatic model(input int n);
      int sum, k, nw, prev, diff;
      bit first;
      sum = 0; k = 0; prev = 144; first = 1'b1;
      ep_t.delete();
      ep_pos.delete();
      for (int w = 1; w < n; w++) begin
         if (!sh[w]) begin
            sum += sv[w];
            k++;
            if (k == 8) begin
               nw = ((sum / 8) * 288) / 4096;
`ifdef PADDLE_HYST_EN
               diff = (nw > prev) ? nw - prev : prev - nw;
               if (first || diff >= 4) prev = nw;
`else
               diff = 0;
               prev = nw;
`endif
               first = 1'b0;
               ep_t.push_back(4 * w + 6);
               ep_pos.push_back(9'(prev));
               sum = 0;
               k = 0;
            end
         end
      end
   endtask

   task automatic assert_reset();
      reset = 1'b1;
      hold = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      got_t.delete();
      got_pos.delete();
      reset = 1'b0;
   endtask

   task automatic play(input int from, input int to);
      for (int w = from; w < to; w++) begin
         adc_result = 12'(sv[w]);
         hold = sh[w];
         repeat (4) @(posedge clk);
         #1;
      end
   endtask

   task automatic tail();
      hold = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      hold = 1'b0;
   endtask

   task automatic fill(input int n, input int val);
      sv.delete();
      sh.delete();
      for (int i = 0; i < n; i++) begin
         sv.push_back(val);
         sh.push_back(1'b0);
      end
   endtask

   task automatic test_reset();
      adc_result = 12'd0;
      assert_reset();
      @(posedge clk); #1;
      tests++;
      if (pos !== 9'd144) begin fails++; $display("FAIL reset_pos got %0d want 144", pos); end
      tests++;
      if (pos_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", pos_valid); end
      tests++;
      if (chan !== 3'd0) begin fails++; $display("FAIL reset_chan got %0d want 0", chan); end
   endtask

   task automatic test_full_scale();
      fill(25, 4095);
      assert_reset(); release_reset();
      play(0, 25); tail(); model(25);
      tests++;
      if (got_t.size() != 3 || ep_t.size() != 3) begin
         fails++; $display("FAIL full_scale_count got %0d want 3", got_t.size());
      end else begin
         tests++;
         if (got_t[0] != 38 || got_pos[0] !== 9'd287) begin
            fails++; $display("FAIL full_scale_first got t=%0d pos=%0d want t=38 pos=287", got_t[0], got_pos[0]);
         end
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_t[i] != ep_t[i] || got_pos[i] !== ep_pos[i]) begin
               fails++; $display("FAIL full_scale_pulse%0d got t=%0d pos=%0d want t=%0d pos=%0d", i, got_t[i], got_pos[i], ep_t[i], ep_pos[i]);
            end
         end
      end
   endtask

   task automatic test_zero();
      fill(17, 0);
      assert_reset(); release_reset();
      play(0, 9);
      tests++;
      if (pos !== 9'd144 || pos_valid !== 1'b0) begin
         fails++; $display("FAIL zero_prepulse got pos=%0d valid=%0b want pos=144 valid=0", pos, pos_valid);
      end
      play(9, 17); tail(); model(17);
      tests++;
      if (got_t.size() != ep_t.size() || got_t.size() < 1) begin
         fails++; $display("FAIL zero_count got %0d want %0d", got_t.size(), ep_t.size());
      end else begin
         tests++;
         if (got_t[0] != 38 || got_pos[0] !== 9'd0) begin
            fails++; $display("FAIL zero_first got t=%0d pos=%0d want t=38 pos=0", got_t[0], got_pos[0]);
         end
      end
   endtask

   task automatic test_deadband();
      logic [8:0] want_mid;
      fill(25, 2048);
      for (int i = 9; i < 17; i++) sv[i] = 2077;
      for (int i = 17; i < 25; i++) sv[i] = 2134;
`ifdef PADDLE_HYST_EN
      want_mid = 9'd144;
`else
      want_mid = 9'd146;
`endif
      assert_reset(); release_reset();
      play(0, 25); tail(); model(25);
      tests++;
      if (got_t.size() != 3 || ep_t.size() != 3) begin
         fails++; $display("FAIL deadband_count got %0d want 3", got_t.size());
      end else begin
         tests++;
         if (got_pos[0] !== 9'd144 || got_pos[1] !== want_mid || got_pos[2] !== 9'd150) begin
            fails++; $display("FAIL deadband_seq got %0d,%0d,%0d want 144,%0d,150", got_pos[0], got_pos[1], got_pos[2], want_mid);
         end
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_t[i] != ep_t[i] || got_pos[i] !== ep_pos[i]) begin
               fails++; $display("FAIL deadband_pulse%0d got t=%0d pos=%0d want t=%0d pos=%0d", i, got_t[i], got_pos[i], ep_t[i], ep_pos[i]);
            end
         end
      end
   endtask

   task automatic test_hold();
      fill(21, 0);
      for (int i = 0; i < 21; i++) sv[i] = int'($urandom_range(0, 4095));
      for (int i = 3; i < 7; i++) sh[i] = 1'b1;
      assert_reset(); release_reset();
      play(0, 21); tail(); model(21);
      tests++;
      if (got_t.size() != ep_t.size() || got_t.size() < 1) begin
         fails++; $display("FAIL hold_count got %0d want %0d", got_t.size(), ep_t.size());
      end else begin
         tests++;
         if (got_t[0] != 54) begin fails++; $display("FAIL hold_delay got t=%0d want t=54", got_t[0]); end
         for (int i = 0; i < ep_t.size(); i++) begin
            tests++;
            if (got_t[i] != ep_t[i] || got_pos[i] !== ep_pos[i]) begin
               fails++; $display("FAIL hold_pulse%0d got t=%0d pos=%0d want t=%0d pos=%0d", i, got_t[i], got_pos[i], ep_t[i], ep_pos[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_batch();
      fill(11, 4095);
      assert_reset(); release_reset();
      play(0, 11);
      tests++;
      if (pos !== 9'd287) begin fails++; $display("FAIL midreset_before got pos=%0d want 287", pos); end
      assert_reset();
      tests++;
      if (pos !== 9'd144 || pos_valid !== 1'b0) begin
         fails++; $display("FAIL midreset_clear got pos=%0d valid=%0b want pos=144 valid=0", pos, pos_valid);
      end
      fill(9, 4095);
      release_reset();
      play(0, 9); tail(); model(9);
      tests++;
      if (got_t.size() != 1 || ep_t.size() != 1) begin
         fails++; $display("FAIL midreset_count got %0d want 1", got_t.size());
      end else begin
         tests++;
         if (got_t[0] != 38 || got_pos[0] !== 9'd287 || got_pos[0] !== ep_pos[0]) begin
            fails++; $display("FAIL midreset_pulse got t=%0d pos=%0d want t=38 pos=287", got_t[0], got_pos[0]);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         fill(40, 0);
         for (int i = 0; i < 40; i++) begin
            sv[i] = int'($urandom_range(0, 4095));
            sh[i] = ($urandom_range(0, 4) == 0);
         end
         assert_reset(); release_reset();
         play(0, 40); tail(); model(40);
         tests++;
         if (got_t.size() != ep_t.size()) begin
            fails++; $display("FAIL random%0d_count got %0d want %0d", r, got_t.size(), ep_t.size());
         end else begin
            for (int i = 0; i < ep_t.size(); i++) begin
               tests++;
               if (got_t[i] != ep_t[i] || got_pos[i] !== ep_pos[i]) begin
                  fails++; $display("FAIL random%0d_pulse%0d got t=%0d pos=%0d want t=%0d pos=%0d", r, i, got_t[i], got_pos[i], ep_t[i], ep_pos[i]);
               end
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      hold = 1'b0;
      adc_result = 12'd0;
      test_reset();
      test_full_scale();
      test_zero();
      test_deadband();
      test_hold();
      test_reset_mid_batch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
